// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two prioritised write ports,
// per-register busy scoreboard. Optional same-cycle write forwarding under REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    wr0_en,
  input  logic [ADDR_W-1:0]       wr0_addr,
  input  logic [DATA_W-1:0]       wr0_data,
  input  logic                    wr1_en,
  input  logic [ADDR_W-1:0]       wr1_addr,
  input  logic [DATA_W-1:0]       wr1_data,
  input  logic                    bs_en,
  input  logic [ADDR_W-1:0]       bs_addr,
  output logic [(1<<ADDR_W)-1:0]  busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q  [1:DEPTH-1];
  logic [DATA_W-1:0] rf_view [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // NOTE: the register array is cleared by reset because software may read any
  // register before writing it; this costs a reset pin per flop, which is accepted here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr1_en && wr1_addr == ADDR_W'(i))      regs_q[i] <= wr1_data;
        else if (wr0_en && wr0_addr == ADDR_W'(i)) regs_q[i] <= wr0_data;
      end
    end
  end

  // Retiring producers clear their bit; a same-cycle issue to that register re-sets it.
  // NOTE: every combinational output gets a default before any conditional update,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < DEPTH; i++) begin
      if ((wr0_en && wr0_addr == ADDR_W'(i)) || (wr1_en && wr1_addr == ADDR_W'(i)))
        busy_d[i] = 1'b0;
      if (bs_en && bs_addr == ADDR_W'(i))
        busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking '=' is reserved for the combinational blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  // Full-depth view with a constant-zero entry 0 keeps the read mux free of special cases.
  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < DEPTH; i++) rf_view[i] = regs_q[i];
  end

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rdv;
  logic              rbv;
`ifdef REGFILE_BYPASS_EN
  logic              hit0;
  logic              hit1;
`endif

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rdv     = '0;
    rbv     = 1'b0;
`ifdef REGFILE_BYPASS_EN
    hit0    = 1'b0;
    hit1    = 1'b0;
`endif
    for (int k = 0; k < NRD; k++) begin
      ra  = rd_addr[k*ADDR_W +: ADDR_W];
      rdv = rf_view[ra];
      rbv = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      hit0 = wr0_en && (wr0_addr == ra) && (ra != '0);
      hit1 = wr1_en && (wr1_addr == ra) && (ra != '0);
      if (hit1)      rdv = wr1_data;
      else if (hit0) rdv = wr0_data;
      if ((hit0 || hit1) && !(bs_en && bs_addr == ra)) rbv = 1'b0;
`endif
      // Reset forces quiet outputs even if forwarding would otherwise drive them.
      if (!rst) begin
        rd_data[k*DATA_W +: DATA_W] = rdv;
        rd_busy[k]                  = rbv;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: a 32x32 four-read-port instance and a
// 16-bit, 8-entry single-read-port instance, checked with immediate assertions.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic [19:0]  rd_addr = '0;
  logic [127:0] rd_data;
  logic [3:0]   rd_busy;
  logic         wr0_en = 1'b0, wr1_en = 1'b0, bs_en = 1'b0;
  logic [4:0]   wr0_addr = '0, wr1_addr = '0, bs_addr = '0;
  logic [31:0]  wr0_data = '0, wr1_data = '0;
  logic [31:0]  busy_vec;

  logic [2:0]   s_rd_addr = '0;
  logic [15:0]  s_rd_data;
  logic [0:0]   s_rd_busy;
  logic         s_wr0_en = 1'b0, s_wr1_en = 1'b0, s_bs_en = 1'b0;
  logic [2:0]   s_wr0_addr = '0, s_wr1_addr = '0, s_bs_addr = '0;
  logic [15:0]  s_wr0_data = '0, s_wr1_data = '0;
  logic [7:0]   s_busy_vec;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(4)) u_dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .bs_en(bs_en), .bs_addr(bs_addr), .busy_vec(busy_vec)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(1)) u_small (
    .clk(clk), .rst(rst),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr0_en(s_wr0_en), .wr0_addr(s_wr0_addr), .wr0_data(s_wr0_data),
    .wr1_en(s_wr1_en), .wr1_addr(s_wr1_addr), .wr1_data(s_wr1_data),
    .bs_en(s_bs_en), .bs_addr(s_bs_addr), .busy_vec(s_busy_vec)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; bs_en = 1'b0;
    s_wr0_en = 1'b0; s_wr1_en = 1'b0; s_bs_en = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [4:0] a);
    rd_addr[k*5 +: 5] = a;
  endtask

  function automatic logic [31:0] rdd(input int k);
    return rd_data[k*32 +: 32];
  endfunction

  initial begin
    // Reset state
    #2;
    check("rst_rd_data", rd_data, '0);
    check("rst_busy_vec", busy_vec, '0);
    check("rst_rd_busy", rd_busy, '0);
    #10 rst = 1'b0;

    // r5 <= DEADBEEF, mark r2 busy
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    bs_en = 1'b1; bs_addr = 5'd2;
    tick(); idle();
    set_rd(0, 5'd5); set_rd(1, 5'd2);
    #1;
    check("r5_written", rdd(0), 32'hDEADBEEF);
    check("r2_busy_vec", busy_vec, 32'h0000_0004);
    check("r2_rd_busy", rd_busy, 4'b0010);

    // Async reset mid-cycle, with a write pending to r5
    rst = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1;
    #1;
    check("async_rst_rd0", rdd(0), 32'h0);
    check("async_rst_busy", busy_vec, '0);
    check("async_rst_rd_busy", rd_busy, '0);
    idle();
    #2 rst = 1'b0;
    tick();
    check("post_rst_r5", rdd(0), 32'h0);
    check("post_rst_busy", busy_vec, '0);

    // Writes and busy-set to r0 are ignored
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h1234;
    bs_en = 1'b1; bs_addr = 5'd0;
    set_rd(0, 5'd0);
    #1;
    check("r0_during_write", rdd(0), 32'h0);
    tick(); idle();
    #1;
    check("r0_reads_zero", rdd(0), 32'h0);
    check("r0_never_busy", busy_vec, '0);

    // Same-address dual write: wr1 wins
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h22;
    tick(); idle();
    set_rd(0, 5'd3);
    #1;
    check("same_addr_wr1_wins", rdd(0), 32'h22);

    // Different-address dual write
    wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'hAA;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hBB;
    tick(); idle();
    set_rd(0, 5'd4); set_rd(1, 5'd7);
    #1;
    check("dual_r4", rdd(0), 32'hAA);
    check("dual_r7", rdd(1), 32'hBB);

    // All four ports read r9
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h5A5A5A5A;
    tick(); idle();
    for (int k = 0; k < 4; k++) set_rd(k, 5'd9);
    #1;
    check("multi_rd0", rdd(0), 32'h5A5A5A5A);
    check("multi_rd1", rdd(1), 32'h5A5A5A5A);
    check("multi_rd2", rdd(2), 32'h5A5A5A5A);
    check("multi_rd3", rdd(3), 32'h5A5A5A5A);

    // Scoreboard: set r8, port 2 watches it
    bs_en = 1'b1; bs_addr = 5'd8;
    tick(); idle();
    set_rd(2, 5'd8);
    #1;
    check("bs_r8_vec", busy_vec, 32'h0000_0100);
    check("bs_r8_rd_busy", rd_busy, 4'b0100);

    // wr1 retires r8; combinational view depends on forwarding
    wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 32'h77;
    #1;
    check("retire_rd_busy_comb", rd_busy, BYP ? 4'b0000 : 4'b0100);
    check("retire_rd_data_comb", rdd(2), BYP ? 32'h77 : 32'h0);
    tick(); idle();
    #1;
    check("retire_busy_clear", busy_vec, '0);
    check("retire_r8_data", rdd(2), 32'h77);

    // Set and clear together: set wins
    bs_en = 1'b1; bs_addr = 5'd8;
    wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 32'h78;
    tick(); idle();
    #1;
    check("set_clear_same_cycle", busy_vec, 32'h0000_0100);

    // Busy r8 re-issued while wr0 retires it: stays busy, never masked
    bs_en = 1'b1; bs_addr = 5'd8;
    wr0_en = 1'b1; wr0_addr = 5'd8; wr0_data = 32'h79;
    #1;
    check("reissue_rd_busy_comb", rd_busy, 4'b0100);
    tick(); idle();
    #1;
    check("reissue_busy_vec", busy_vec, 32'h0000_0100);

    // wr0 alone clears
    wr0_en = 1'b1; wr0_addr = 5'd8; wr0_data = 32'h80;
    #1;
    check("wr0_clear_rd_busy_comb", rd_busy, BYP ? 4'b0000 : 4'b0100);
    tick(); idle();
    #1;
    check("wr0_clear_busy_vec", busy_vec, '0);
    check("wr0_clear_r8_data", rdd(2), 32'h80);

    // Busy-set on r0 is ignored
    bs_en = 1'b1; bs_addr = 5'd0;
    tick(); idle();
    #1;
    check("bs_r0_ignored", busy_vec, '0);

    // Forwarding: r6=1, then write 0x99 while reading r6
    wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h1;
    tick(); idle();
    set_rd(0, 5'd6);
    wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h99;
    #1;
    check("bypass_same_cycle", rdd(0), BYP ? 32'h99 : 32'h1);
    tick(); idle();
    #1;
    check("bypass_next_cycle", rdd(0), 32'h99);

    // Forwarding priority: wr1 over wr0
    wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'hAB;
    wr1_en = 1'b1; wr1_addr = 5'd6; wr1_data = 32'hCD;
    #1;
    check("bypass_prio_comb", rdd(0), BYP ? 32'hCD : 32'h99);
    tick(); idle();
    #1;
    check("bypass_prio_stored", rdd(0), 32'hCD);

    // Small instance: 16-bit data, 8 entries
    s_wr0_en = 1'b1; s_wr0_addr = 3'd7; s_wr0_data = 16'hFFFF;
    s_bs_en = 1'b1; s_bs_addr = 3'd7;
    tick(); idle();
    s_rd_addr = 3'd7;
    #1;
    check("small_r7", s_rd_data, 16'hFFFF);
    check("small_busy_vec", s_busy_vec, 8'h80);
    check("small_rd_busy", s_rd_busy, 1'b1);
    s_wr1_en = 1'b1; s_wr1_addr = 3'd7; s_wr1_data = 16'h1234;
    tick(); idle();
    #1;
    check("small_r7_wr1", s_rd_data, 16'h1234);
    check("small_busy_clear", s_busy_vec, 8'h00);
    s_rd_addr = 3'd0;
    #1;
    check("small_r0", s_rd_data, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
